// File: rtl/alaw_enc_seq.sv
// A-law style compander: sequential exponent search, one exponent tested per cycle.
// Latency: 1 accept cycle, 1..7 SEARCH cycles (8-e for e>=1, 7 for e=0), then held in EMIT until taken.
// Backpressure: IN_READY only in IDLE; OUT_CODE/OUT_VALID held until OUT_READY. Optional stats: ALAW_ENC_STATS_EN.
module alaw_enc_seq #(
  parameter int SAT_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [11:0]          IN_DATA,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [7:0]           OUT_CODE,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY
`ifdef ALAW_ENC_STATS_EN
  ,
  output logic [SAT_CNT_W-1:0] SAT_COUNT
`endif
);

  if (SAT_CNT_W < 1) begin : g_bad_sat_cnt_w
    $error("alaw_enc_seq: SAT_CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t      state_q;
  logic [11:0] mag_q;
  logic [2:0]  exp_q;
  logic        sign_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [7:0]  out_code_q;

  logic [11:0]        mag_d;
  logic [2:0]         exp_sel_d;
  logic [7:0]         code_d;
  logic [11:0]        thresh;
  logic               hit;
  logic               done;
  logic [11:0]        shifted;
  logic signed [12:0] diff;
  logic [3:0]         mant;
  logic [7:0]         mag_code;
`ifdef ALAW_ENC_STATS_EN
  logic               sat;
`endif

  // Magnitude of the incoming sample, exponent test for the current step, and the resulting code.
  always_comb begin
    // -2048 maps to 12'h800 = 2048, still representable as unsigned 12-bit.
    mag_d     = IN_DATA[11] ? (~IN_DATA + 12'd1) : IN_DATA;
    thresh    = 12'd17 << exp_q;
    hit       = (mag_q >= thresh);
    // A miss at e=1 falls straight through to the linear segment in the same cycle.
    done      = hit || (exp_q == 3'd1);
    exp_sel_d = hit ? exp_q : 3'd0;
    shifted   = (exp_sel_d == 3'd0) ? (mag_q >> 1) : (mag_q >> exp_sel_d);
    diff      = $signed({1'b0, shifted}) - ((exp_sel_d == 3'd0) ? 13'sd9 : 13'sd17);
`ifdef ALAW_ENC_STATS_EN
    sat       = 1'b0;
`endif
    if (diff < 13'sd0) begin
      mant = 4'd0;
    end else if (diff > 13'sd15) begin
      mant = 4'd15;
`ifdef ALAW_ENC_STATS_EN
      sat  = 1'b1;
`endif
    end else begin
      mant = diff[3:0];
    end
    mag_code = {1'b0, mant, exp_sel_d};
    // Two's-complement negation keeps a zero magnitude at 0x00 for either sign.
    code_d   = sign_q ? (~mag_code + 8'd1) : mag_code;
  end

  // Control FSM with registered handshake and code outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      mag_q       <= 12'd0;
      exp_q       <= 3'd0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_code_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID && in_ready_q) begin
            mag_q      <= mag_d;
            sign_q     <= IN_DATA[11];
            exp_q      <= 3'd7;
            in_ready_q <= 1'b0;
            state_q    <= SEARCH;
          end
        end
        SEARCH: begin
          if (done) begin
            exp_q       <= exp_sel_d;
            out_code_q  <= code_d;
            out_valid_q <= 1'b1;
            state_q     <= EMIT;
          end else begin
            exp_q <= exp_q - 3'd1;
          end
        end
        EMIT: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef ALAW_ENC_STATS_EN
  logic [SAT_CNT_W-1:0] sat_cnt_q;

  // Count upper mantissa clamps as each code enters EMIT; sticks at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sat_cnt_q <= '0;
    end else if ((state_q == SEARCH) && done && sat && (sat_cnt_q != '1)) begin
      sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

  assign SAT_COUNT = sat_cnt_q;
`endif

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_CODE  = out_code_q;

endmodule

// File: doc/alaw_enc_seq.md
ALAW_ENC_SEQ -- requirements
Module: alaw_enc_seq

Interface
REQ-001 SHALL have parameter SAT_CNT_W, default 8, width of the saturation counter.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port IN_DATA  input  12  signed two's-complement linear sample.
REQ-005 SHALL have port IN_VALID  input  1  IN_DATA is valid.
REQ-006 SHALL have port IN_READY  output  1  block can accept a sample.
REQ-007 SHALL have port OUT_CODE  output  8  companded code, in the format the downstream decoder consumes.
REQ-008 SHALL have port OUT_VALID  output  1  OUT_CODE is valid.
REQ-009 SHALL have port OUT_READY  input  1  the consumer takes OUT_CODE.
REQ-010 SHALL have port SAT_COUNT  output  SAT_CNT_W  count of mantissa-clamp events; present only under ALAW_ENC_STATS_EN.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SEARCH, EMIT.
REQ-012 SHALL assert IN_READY only in IDLE; IN_VALID&IN_READY latches IN_DATA, forms magnitude M (0..2048, 12-bit unsigned), records sign S=IN_DATA[11], sets e=7, and enters SEARCH.
REQ-013 SHALL test one exponent per SEARCH cycle: if M >= 17*2^e, select e; otherwise decrement e; if the e=1 test fails, select e=0 in that same cycle.
REQ-014 SHALL spend 8-e SEARCH cycles for a selected e of 1..7, and 7 cycles for e=0.
REQ-015 SHALL compute the mantissa for e>=1 as m=(M>>e)-17, clamped to 15 on overflow.
REQ-016 SHALL compute the mantissa for e=0 as m=(M>>1)-9, clamped to 0..15.
REQ-017 SHALL form magnitude code C={1'b0, m[3:0], e[2:0]}.
REQ-018 SHALL set OUT_CODE=C when S=0, and (~C+1) mod 256 when S=1; C=0x00 SHALL always yield 0x00.
REQ-019 SHALL, on leaving SEARCH, register OUT_CODE, assert OUT_VALID and enter EMIT.
REQ-020 SHALL hold OUT_CODE and OUT_VALID stable in EMIT until OUT_READY=1; on that cycle it SHALL deassert OUT_VALID and return to IDLE.
REQ-021 SHALL ignore IN_VALID outside IDLE; the upstream source holds its sample.
REQ-022 SHALL treat a clamp to 15 under REQ-015 or REQ-016 (upper clamp) as a saturation event; a lower clamp to 0 SHALL NOT count.

Reset
REQ-023 SHALL, while RST=1, force state=IDLE, IN_READY=1 after release, OUT_VALID=0, OUT_CODE=0x00, SAT_COUNT=0, and internal M/e/S=0.
REQ-024 SHALL abandon a sample in SEARCH or EMIT when RST asserts; no code for that sample is ever emitted.

Configuration
REQ-025 SHALL define the macro ALAW_ENC_STATS_EN: when it is defined, SAT_COUNT exists and increments by 1 per saturation event at EMIT entry, saturating at 2^SAT_CNT_W-1.
REQ-026 SHALL, when ALAW_ENC_STATS_EN is undefined, omit the SAT_COUNT port and counter logic; all other behaviour is identical.

Verification
REQ-027 SHALL cover: IN_DATA=+1000 -> e=5, 3 SEARCH cycles, OUT_CODE=0x75 (decodes to 992).
REQ-028 SHALL cover: IN_DATA=-2048 (0x800) -> e=6, OUT_CODE=0x82 (decodes to -2048); IN_DATA=+2047 -> OUT_CODE=0x76.
REQ-029 SHALL cover: IN_DATA=+40 -> e=1, 7 SEARCH cycles, OUT_CODE=0x19; IN_DATA=0 and IN_DATA=-5 -> OUT_CODE=0x00, SAT_COUNT unchanged.
REQ-030 SHALL cover: IN_DATA=+1087 -> e=5, m clamped to 15, OUT_CODE=0x7D, SAT_COUNT +1 (STATS_EN build); repeated 300 times -> SAT_COUNT=255.
REQ-031 SHALL cover: OUT_READY held low 10 cycles in EMIT -> OUT_CODE/OUT_VALID stable and IN_READY=0; OUT_READY=1 -> IDLE on the next cycle.
REQ-032 SHALL cover: RST pulsed during SEARCH -> OUT_VALID stays 0, state IDLE, and the next sample encodes correctly.
